sync_fifo_flex: RTL and testbench

Parametrised single-clock FIFO, successor to the fixed 16x32 sync FIFO used between datapath stages. Adds non-power-of-two depth, a selectable read mode (show-ahead or one-cycle registered read), a live occupancy count, runtime-programmable almost-full/almost-empty thresholds, synchronous flush and sticky overflow/underflow error flags. It sits between producer/consumer stages in the same clock domain, for example between the DMA front end and the core array buffers.

---
 rtl/sync_fifo_pkg.sv | 21 ++
 rtl/sync_fifo_flex_if.sv | 53 +++++
 rtl/sync_fifo_flex_mem.sv | 50 +++++
 rtl/sync_fifo_flex.sv | 149 ++++++++++++++
 tb/tb_sync_fifo_flex.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_pkg.sv
// -----------------------------------------------------------------------------
// sync_fifo_pkg
// Shared definitions for the sync_fifo_flex block.
//   FIFO_FWFT / FIFO_REGRD : values for the FWFT read-mode parameter
//   cnt_width(depth)        : bits needed to hold an occupancy of 0..depth
//   ptr_width(depth)        : bits needed to hold an index of 0..depth-1
// -----------------------------------------------------------------------------
package sync_fifo_pkg;

   localparam int FIFO_FWFT  = 1;   // show-ahead: head word always on rd_data
   localparam int FIFO_REGRD = 0;   // registered read: data one cycle after rd_en

   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/sync_fifo_flex_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_flex_if
// Bundles the producer/consumer handshake, status and control signals of
// sync_fifo_flex. The FIFO connects through the slave modport, the
// surrounding stages (or a bench) through the master modport.
//
// Handshake: a write transfers on a rising clock edge when wr_en and
// wr_ready are both high; a read pops on an edge when rd_en is high and the
// FIFO is not empty. wr_ready never depends on wr_en, and flush blocks both.
//
//   flush, wr_en, wr_data, rd_en, af_thresh, ae_thresh, err_clr : to FIFO
//   wr_ready, rd_data, rd_valid, count, almost_full, almost_empty,
//   full, empty, overflow, underflow                            : from FIFO
// -----------------------------------------------------------------------------
interface sync_fifo_flex_if
   import sync_fifo_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   parameter int CNT_W = cnt_width(DEPTH)
);

   logic             flush;
   logic             wr_en;
   logic [WIDTH-1:0] wr_data;
   logic             wr_ready;
   logic             rd_en;
   logic [WIDTH-1:0] rd_data;
   logic             rd_valid;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] af_thresh;
   logic [CNT_W-1:0] ae_thresh;
   logic             almost_full;
   logic             almost_empty;
   logic             full;
   logic             empty;
   logic             overflow;
   logic             underflow;
   logic             err_clr;

   modport slave (
      input  flush, wr_en, wr_data, rd_en, af_thresh, ae_thresh, err_clr,
      output wr_ready, rd_data, rd_valid, count, almost_full, almost_empty,
             full, empty, overflow, underflow
   );

   modport master (
      output flush, wr_en, wr_data, rd_en, af_thresh, ae_thresh, err_clr,
      input  wr_ready, rd_data, rd_valid, count, almost_full, almost_empty,
             full, empty, overflow, underflow
   );

endinterface

// File: rtl/sync_fifo_flex_mem.sv
// -----------------------------------------------------------------------------
// sync_fifo_mem
// DEPTH x WIDTH storage array for sync_fifo_flex.
//   clock, rst : rising-edge clock, asynchronous active-high reset (zeroes array)
//   wr_en, wr_addr, wr_data : synchronous write port
//   rd_addr, rd_data        : asynchronous (combinational) read port
// -----------------------------------------------------------------------------
module sync_fifo_mem
   import sync_fifo_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   parameter int PTR_W = ptr_width(DEPTH)
) (
   input  logic             clock,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [PTR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [PTR_W-1:0] rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];

   // Address compare per word keeps non-power-of-two depths from ever
   // decoding an index past the end of the array.
   always_comb begin
      mem_d = mem_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (wr_en && (wr_addr == PTR_W'(i))) begin
            mem_d[i] = wr_data;
         end
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/sync_fifo_flex.sv
// -----------------------------------------------------------------------------
// sync_fifo_flex
// Single-clock FIFO with arbitrary depth, selectable read mode, live
// occupancy, programmable almost-full/almost-empty thresholds, synchronous
// flush and sticky overflow/underflow flags.
//   clock : rising-edge clock
//   rst   : asynchronous active-high reset
//   bus   : sync_fifo_flex_if.slave (data handshake, status, control)
// Parameters: WIDTH (word bits), DEPTH (entries, >=2), FWFT (1 show-ahead,
// 0 registered read), CNT_W (derived count width, leave at default).
// -----------------------------------------------------------------------------
module sync_fifo_flex
   import sync_fifo_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   parameter int FWFT  = FIFO_FWFT,
   parameter int CNT_W = cnt_width(DEPTH)
) (
   input  logic             clock,
   input  logic             rst,
   sync_fifo_flex_if.slave  bus
);

   localparam int               PTR_W    = ptr_width(DEPTH);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             underflow_q, underflow_d;
   logic             rd_valid_q, rd_valid_d;
   logic [WIDTH-1:0] rd_data_q, rd_data_d;
   logic [WIDTH-1:0] mem_rd_data;

   logic full;
   logic empty;
   logic rd_acc;
   logic wr_acc;
   logic wr_ready;

   // Index advance with wrap at DEPTH-1, so any depth works without
   // wrap-parity bits; occupancy comes from the count register alone.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
   endfunction

   assign full  = (count_q == CNT_FULL);
   assign empty = (count_q == '0);

   // A read frees the slot a same-cycle write needs, so full does not block
   // a write paired with a read. There is no empty bypass: a read of an
   // empty FIFO is never accepted, even alongside a write.
   assign rd_acc   = bus.rd_en & ~empty & ~bus.flush;
   assign wr_ready = (~full | rd_acc) & ~bus.flush;
   assign wr_acc   = bus.wr_en & wr_ready;

   always_comb begin
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      rd_data_d   = rd_data_q;
      rd_valid_d  = 1'b0;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;

      if (bus.flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (rd_acc) begin
            head_d     = ptr_inc(head_q);
            rd_data_d  = mem_rd_data;
            rd_valid_d = 1'b1;
         end
         if (wr_acc) begin
            tail_d = ptr_inc(tail_q);
         end
         if (wr_acc && !rd_acc) begin
            count_d = count_q + CNT_W'(1);
         end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CNT_W'(1);
         end
      end

      // Clear first so a same-cycle error still sets the flag.
      if (bus.err_clr) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
      if (bus.wr_en && !wr_ready && !bus.flush) begin
         overflow_d = 1'b1;
      end
      if (bus.rd_en && empty && !bus.flush) begin
         underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_valid_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   sync_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_mem (
      .clock   (clock),
      .rst     (rst),
      .wr_en   (wr_acc),
      .wr_addr (tail_q),
      .wr_data (bus.wr_data),
      .rd_addr (head_q),
      .rd_data (mem_rd_data)
   );

   // Show-ahead exposes the head word directly; registered read presents
   // the word popped on the previous edge with a one-cycle valid pulse.
   assign bus.rd_data      = (FWFT != FIFO_REGRD) ? mem_rd_data : rd_data_q;
   assign bus.rd_valid     = (FWFT != FIFO_REGRD) ? ~empty      : rd_valid_q;
   assign bus.wr_ready     = wr_ready;
   assign bus.count        = count_q;
   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.almost_full  = (count_q >= bus.af_thresh);
   assign bus.almost_empty = (count_q <= bus.ae_thresh);
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_flex.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_flex
// Drives two DEPTH=5 FIFOs with identical stimulus: u_fwft (show-ahead) and
// u_regrd (registered read). A queue-based reference model tracks contents,
// the registered-read output word/pulse and the sticky error flags.
// -----------------------------------------------------------------------------
module tb_sync_fifo_flex;

   localparam int W  = 16;
   localparam int D  = 5;
   localparam int CW = 3;

   logic          clk;
   logic          rst;
   logic          flush;
   logic          wr_en;
   logic [W-1:0]  wr_data;
   logic          rd_en;
   logic          err_clr;
   logic [CW-1:0] af_thresh;
   logic [CW-1:0] ae_thresh;

   int total = 0;
   int bad   = 0;

   // reference model state
   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_b_data;
   logic         exp_b_valid;
   logic         exp_ovf;
   logic         exp_udf;

   sync_fifo_flex_if #(.WIDTH(W), .DEPTH(D)) if_a ();
   sync_fifo_flex_if #(.WIDTH(W), .DEPTH(D)) if_b ();

   assign if_a.flush = flush;     assign if_b.flush = flush;
   assign if_a.wr_en = wr_en;     assign if_b.wr_en = wr_en;
   assign if_a.wr_data = wr_data; assign if_b.wr_data = wr_data;
   assign if_a.rd_en = rd_en;     assign if_b.rd_en = rd_en;
   assign if_a.err_clr = err_clr; assign if_b.err_clr = err_clr;
   assign if_a.af_thresh = af_thresh; assign if_b.af_thresh = af_thresh;
   assign if_a.ae_thresh = ae_thresh; assign if_b.ae_thresh = ae_thresh;

   sync_fifo_flex #(.WIDTH(W), .DEPTH(D), .FWFT(1)) u_fwft (
      .clock (clk),
      .rst   (rst),
      .bus   (if_a)
   );

   sync_fifo_flex #(.WIDTH(W), .DEPTH(D), .FWFT(0)) u_regrd (
      .clock (clk),
      .rst   (rst),
      .bus   (if_b)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   // ---------------- driver tasks ----------------
   task automatic drive(input logic we, input logic [W-1:0] wd, input logic re,
                        input logic fl, input logic ec);
      wr_en   = we;
      wr_data = wd;
      rd_en   = re;
      flush   = fl;
      err_clr = ec;
   endtask

   task automatic model_reset();
      exp_q.delete();
      exp_b_data  = '0;
      exp_b_valid = 1'b0;
      exp_ovf     = 1'b0;
      exp_udf     = 1'b0;
   endtask

   // Clock one edge and advance the reference model with the driven inputs;
   // returns #1 after the edge so outputs can be sampled.
   task automatic tick();
      int           sz;
      logic         rd_ok;
      logic         wr_ok;
      logic [W-1:0] popped;
      sz     = exp_q.size();
      popped = '0;
      @(posedge clk);
      if (flush) begin
         exp_q.delete();
         exp_b_valid = 1'b0;
         if (err_clr) begin
            exp_ovf = 1'b0;
            exp_udf = 1'b0;
         end
      end else begin
         rd_ok = rd_en && (sz > 0);
         wr_ok = wr_en && ((sz < D) || rd_ok);
         if (rd_ok) popped = exp_q.pop_front();
         if (wr_ok) exp_q.push_back(wr_data);
         exp_b_valid = rd_ok;
         if (rd_ok) exp_b_data = popped;
         if (wr_en && !wr_ok) exp_ovf = 1'b1;
         else if (err_clr)    exp_ovf = 1'b0;
         if (rd_en && (sz == 0)) exp_udf = 1'b1;
         else if (err_clr)       exp_udf = 1'b0;
      end
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      af_thresh = 3'd0;
      ae_thresh = 3'd1;
      model_reset();
      #2;
      total++; if (if_a.count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", if_a.count); end
      total++; if (if_a.empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", if_a.empty); end
      total++; if (if_a.full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", if_a.full); end
      total++; if (if_a.rd_valid !== 1'b0) begin bad++; $display("FAIL reset_a_valid got=%b exp=0", if_a.rd_valid); end
      total++; if (if_b.rd_valid !== 1'b0) begin bad++; $display("FAIL reset_b_valid got=%b exp=0", if_b.rd_valid); end
      total++; if (if_a.rd_data !== 16'h0) begin bad++; $display("FAIL reset_a_data got=%h exp=0", if_a.rd_data); end
      total++; if (if_b.rd_data !== 16'h0) begin bad++; $display("FAIL reset_b_data got=%h exp=0", if_b.rd_data); end
      total++; if ({if_a.overflow, if_a.underflow} !== 2'b00) begin bad++; $display("FAIL reset_err got=%b exp=00", {if_a.overflow, if_a.underflow}); end
      total++; if (if_a.almost_full !== 1'b1) begin bad++; $display("FAIL reset_af0 got=%b exp=1", if_a.almost_full); end
      total++; if (if_a.almost_empty !== 1'b1) begin bad++; $display("FAIL reset_ae got=%b exp=1", if_a.almost_empty); end
      af_thresh = 3'd3;
      #1;
      total++; if (if_a.almost_full !== 1'b0) begin bad++; $display("FAIL reset_af3 got=%b exp=0", if_a.almost_full); end
      total++; if (if_a.wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready got=%b exp=1", if_a.wr_ready); end
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_wrap();
      for (int i = 1; i <= 5; i++) begin
         drive(1'b1, W'(i), 1'b0, 1'b0, 1'b0);
         tick();
         total++; if (if_a.count !== CW'(i)) begin bad++; $display("FAIL wrap_fill_count got=%0d exp=%0d", if_a.count, i); end
      end
      total++; if (if_a.full !== 1'b1) begin bad++; $display("FAIL wrap_full got=%b exp=1", if_a.full); end
      for (int i = 1; i <= 3; i++) begin
         total++; if (if_a.rd_data !== W'(i)) begin bad++; $display("FAIL wrap_pop_a got=%0d exp=%0d", if_a.rd_data, i); end
         drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
         tick();
         total++; if (if_b.rd_valid !== 1'b1 || if_b.rd_data !== W'(i)) begin bad++; $display("FAIL wrap_pop_b got=%b/%0d exp=1/%0d", if_b.rd_valid, if_b.rd_data, i); end
      end
      for (int i = 6; i <= 8; i++) begin
         drive(1'b1, W'(i), 1'b0, 1'b0, 1'b0);
         tick();
      end
      for (int i = 4; i <= 8; i++) begin
         total++; if (if_a.rd_data !== W'(i)) begin bad++; $display("FAIL wrap_pop2_a got=%0d exp=%0d", if_a.rd_data, i); end
         drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
         tick();
         total++; if (if_b.rd_data !== W'(i)) begin bad++; $display("FAIL wrap_pop2_b got=%0d exp=%0d", if_b.rd_data, i); end
      end
      total++; if (if_a.empty !== 1'b1 || if_a.rd_valid !== 1'b0) begin bad++; $display("FAIL wrap_empty got=%b/%b exp=1/0", if_a.empty, if_a.rd_valid); end
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      tick();
   endtask

   task automatic test_full_rw();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, W'(16 + i), 1'b0, 1'b0, 1'b0);
         tick();
      end
      drive(1'b1, 16'h00AA, 1'b1, 1'b0, 1'b0);
      #1;
      total++; if (if_a.wr_ready !== 1'b1) begin bad++; $display("FAIL fullrw_ready got=%b exp=1", if_a.wr_ready); end
      tick();
      total++; if (if_a.count !== 3'd5) begin bad++; $display("FAIL fullrw_count got=%0d exp=5", if_a.count); end
      total++; if (if_a.overflow !== 1'b0) begin bad++; $display("FAIL fullrw_ovf got=%b exp=0", if_a.overflow); end
      total++; if (if_a.rd_data !== 16'd17) begin bad++; $display("FAIL fullrw_head got=%0d exp=17", if_a.rd_data); end
      total++; if (if_b.rd_valid !== 1'b1 || if_b.rd_data !== 16'd16) begin bad++; $display("FAIL fullrw_b got=%b/%0d exp=1/16", if_b.rd_valid, if_b.rd_data); end
      drive(1'b1, 16'h00BB, 1'b0, 1'b0, 1'b0);
      #1;
      total++; if (if_a.wr_ready !== 1'b0) begin bad++; $display("FAIL full_ready got=%b exp=0", if_a.wr_ready); end
      tick();
      total++; if (if_a.overflow !== 1'b1 || if_b.overflow !== 1'b1) begin bad++; $display("FAIL full_ovf got=%b/%b exp=1/1", if_a.overflow, if_b.overflow); end
      total++; if (if_a.count !== 3'd5) begin bad++; $display("FAIL full_count got=%0d exp=5", if_a.count); end
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
      tick();
      total++; if (if_a.overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b exp=0", if_a.overflow); end
   endtask

   task automatic test_empty_rd();
      drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
      tick();
      drive(1'b1, 16'h0033, 1'b1, 1'b0, 1'b0);
      tick();
      total++; if (if_a.count !== 3'd1) begin bad++; $display("FAIL emptyrw_count got=%0d exp=1", if_a.count); end
      total++; if (if_a.underflow !== 1'b1) begin bad++; $display("FAIL emptyrw_udf got=%b exp=1", if_a.underflow); end
      total++; if (if_a.rd_data !== 16'h0033) begin bad++; $display("FAIL emptyrw_data got=%h exp=0033", if_a.rd_data); end
      total++; if (if_b.rd_valid !== 1'b0) begin bad++; $display("FAIL emptyrw_b_valid got=%b exp=0", if_b.rd_valid); end
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
      tick();
      total++; if (if_a.underflow !== 1'b0) begin bad++; $display("FAIL udf_clr got=%b exp=0", if_a.underflow); end
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      tick();
      total++; if (if_a.underflow !== 1'b0 || if_a.empty !== 1'b1) begin bad++; $display("FAIL last_pop got=%b/%b exp=0/1", if_a.underflow, if_a.empty); end
      drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
      tick();
      total++; if (if_a.underflow !== 1'b1 || if_b.underflow !== 1'b1) begin bad++; $display("FAIL udf_set_wins got=%b/%b exp=1/1", if_a.underflow, if_b.underflow); end
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
      tick();
   endtask

   task automatic test_regrd_latency();
      drive(1'b1, 16'h0011, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 16'h0022, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      #1;
      total++; if (if_b.rd_valid !== 1'b0) begin bad++; $display("FAIL regrd_early got=%b exp=0", if_b.rd_valid); end
      tick();
      total++; if (if_b.rd_valid !== 1'b1 || if_b.rd_data !== 16'h0011) begin bad++; $display("FAIL regrd_pulse got=%b/%h exp=1/0011", if_b.rd_valid, if_b.rd_data); end
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      tick();
      total++; if (if_b.rd_valid !== 1'b0 || if_b.rd_data !== 16'h0011) begin bad++; $display("FAIL regrd_hold got=%b/%h exp=0/0011", if_b.rd_valid, if_b.rd_data); end
      total++; if (if_a.rd_data !== 16'h0022) begin bad++; $display("FAIL fwft_next got=%h exp=0022", if_a.rd_data); end
   endtask

   task automatic test_flush();
      drive(1'b1, 16'h0044, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 16'h0055, 1'b0, 1'b0, 1'b0);
      tick();
      total++; if (if_a.count !== 3'd3) begin bad++; $display("FAIL flush_pre got=%0d exp=3", if_a.count); end
      drive(1'b1, 16'h0066, 1'b1, 1'b1, 1'b0);
      #1;
      total++; if (if_a.wr_ready !== 1'b0) begin bad++; $display("FAIL flush_ready got=%b exp=0", if_a.wr_ready); end
      tick();
      total++; if (if_a.count !== 3'd0 || if_a.empty !== 1'b1) begin bad++; $display("FAIL flush_state got=%0d/%b exp=0/1", if_a.count, if_a.empty); end
      total++; if ({if_a.overflow, if_a.underflow, if_b.rd_valid} !== 3'b000) begin bad++; $display("FAIL flush_flags got=%b exp=000", {if_a.overflow, if_a.underflow, if_b.rd_valid}); end
      drive(1'b1, 16'h0077, 1'b0, 1'b0, 1'b0);
      tick();
      total++; if (if_a.rd_data !== 16'h0077 || if_a.count !== 3'd1) begin bad++; $display("FAIL flush_after got=%h/%0d exp=0077/1", if_a.rd_data, if_a.count); end
      drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
      tick();
   endtask

   task automatic test_thresholds();
      af_thresh = 3'd4;
      ae_thresh = 3'd1;
      for (int c = 0; c <= 5; c++) begin
         #1;
         total++; if (if_a.count !== CW'(c)) begin bad++; $display("FAIL thr_count got=%0d exp=%0d", if_a.count, c); end
         total++; if (if_a.almost_empty !== (c <= 1)) begin bad++; $display("FAIL thr_ae c=%0d got=%b", c, if_a.almost_empty); end
         total++; if (if_a.almost_full !== (c >= 4)) begin bad++; $display("FAIL thr_af c=%0d got=%b", c, if_a.almost_full); end
         if (c < 5) begin
            drive(1'b1, W'(c), 1'b0, 1'b0, 1'b0);
            tick();
            drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
         end
      end
      af_thresh = 3'd6;
      #1;
      total++; if (if_a.almost_full !== 1'b0) begin bad++; $display("FAIL thr_live6 got=%b exp=0", if_a.almost_full); end
      af_thresh = 3'd5;
      #1;
      total++; if (if_a.almost_full !== 1'b1) begin bad++; $display("FAIL thr_live5 got=%b exp=1", if_a.almost_full); end
      drive(1'b0, '0, 1'b0, 1'b1, 1'b0);
      tick();
   endtask

   task automatic test_random();
      int   sz;
      logic exp_ready;
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 99) < ((i % 100) < 50 ? 75 : 30), W'($urandom),
               $urandom_range(0, 99) < ((i % 100) < 50 ? 30 : 75),
               $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 8);
         af_thresh = CW'($urandom_range(0, 6));
         ae_thresh = CW'($urandom_range(0, 6));
         #1;
         sz = exp_q.size();
         exp_ready = !flush && ((sz < D) || (rd_en && sz > 0));
         total++; if (if_a.wr_ready !== exp_ready) begin bad++; $display("FAIL rnd_ready i=%0d got=%b exp=%b", i, if_a.wr_ready, exp_ready); end
         total++; if (if_a.almost_full !== (sz >= int'(af_thresh)) || if_a.almost_empty !== (sz <= int'(ae_thresh))) begin bad++; $display("FAIL rnd_thr i=%0d got=%b%b sz=%0d", i, if_a.almost_full, if_a.almost_empty, sz); end
         tick();
         sz = exp_q.size();
         total++; if (if_a.count !== CW'(sz) || if_b.count !== CW'(sz)) begin bad++; $display("FAIL rnd_count i=%0d got=%0d/%0d exp=%0d", i, if_a.count, if_b.count, sz); end
         total++; if (if_a.full !== (sz == D) || if_a.empty !== (sz == 0)) begin bad++; $display("FAIL rnd_fe i=%0d got=%b%b sz=%0d", i, if_a.full, if_a.empty, sz); end
         total++; if (if_a.rd_valid !== (sz > 0)) begin bad++; $display("FAIL rnd_a_valid i=%0d got=%b sz=%0d", i, if_a.rd_valid, sz); end
         if (sz > 0) begin
            total++; if (if_a.rd_data !== exp_q[0]) begin bad++; $display("FAIL rnd_a_data i=%0d got=%h exp=%h", i, if_a.rd_data, exp_q[0]); end
         end
         total++; if (if_b.rd_valid !== exp_b_valid || if_b.rd_data !== exp_b_data) begin bad++; $display("FAIL rnd_b i=%0d got=%b/%h exp=%b/%h", i, if_b.rd_valid, if_b.rd_data, exp_b_valid, exp_b_data); end
         total++; if (if_a.overflow !== exp_ovf || if_a.underflow !== exp_udf || if_b.overflow !== exp_ovf || if_b.underflow !== exp_udf) begin bad++; $display("FAIL rnd_err i=%0d got=%b%b exp=%b%b", i, if_a.overflow, if_a.underflow, exp_ovf, exp_udf); end
      end
   endtask

   task automatic test_reset_mid();
      drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
      tick();
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, W'(16'h0100 + i), 1'b0, 1'b0, 1'b0);
         tick();
      end
      drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
      tick();
      total++; if (if_b.rd_valid !== 1'b1 || if_a.overflow !== 1'b1) begin bad++; $display("FAIL rstmid_pre got=%b/%b exp=1/1", if_b.rd_valid, if_a.overflow); end
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
      af_thresh = 3'd2;
      rst = 1'b1;
      model_reset();
      #1;
      total++; if (if_a.count !== 3'd0 || if_a.empty !== 1'b1 || if_a.full !== 1'b0) begin bad++; $display("FAIL rstmid_cnt got=%0d/%b/%b exp=0/1/0", if_a.count, if_a.empty, if_a.full); end
      total++; if (if_b.rd_valid !== 1'b0 || if_b.rd_data !== 16'h0) begin bad++; $display("FAIL rstmid_b got=%b/%h exp=0/0", if_b.rd_valid, if_b.rd_data); end
      total++; if (if_a.rd_data !== 16'h0 || if_a.rd_valid !== 1'b0) begin bad++; $display("FAIL rstmid_a got=%h/%b exp=0/0", if_a.rd_data, if_a.rd_valid); end
      total++; if ({if_a.overflow, if_a.underflow} !== 2'b00) begin bad++; $display("FAIL rstmid_err got=%b exp=00", {if_a.overflow, if_a.underflow}); end
      total++; if (if_a.almost_full !== 1'b0 || if_a.almost_empty !== 1'b1) begin bad++; $display("FAIL rstmid_thr got=%b%b exp=01", if_a.almost_full, if_a.almost_empty); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(1'b1, 16'h0ABC, 1'b0, 1'b0, 1'b0);
      tick();
      total++; if (if_a.rd_data !== 16'h0ABC || if_a.count !== 3'd1) begin bad++; $display("FAIL rstmid_after got=%h/%0d exp=0abc/1", if_a.rd_data, if_a.count); end
      drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_wrap();
      test_full_rw();
      test_empty_rd();
      test_regrd_latency();
      test_flush();
      test_thresholds();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
